// File: rtl/bg_scroller.sv
// Background sprite x-position generator: scroll left per frame, park off-screen for a pseudo-random gap, respawn at right edge.
// Outputs registered, updated on the active-tick edge; no backpressure (frame ticks are never stalled, i_run=0 freezes).
module bg_scroller #(
    parameter int         CONV      = 0,
    parameter logic [9:0] SPAWN_X   = 10'd648,
    parameter logic [5:0] MIN_GAP   = 6'd8,
    parameter logic [7:0] LFSR_SEED = 8'hA5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_frame_tick,
    input  logic            i_run,
    input  logic            i_restart,
    input  logic [3:0]      i_speed,
    output logic [9-CONV:0] o_xpos,
    output logic            o_passed
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_SCROLL = 2'd2
    } state_t;

    state_t      r_state;
    logic [9:0]  r_xpos;
    logic [5:0]  r_wait_cnt;
    logic [7:0]  r_lfsr;
    logic        r_passed;

    state_t      w_state_nxt;
    logic [9:0]  w_xpos_nxt;
    logic [5:0]  w_wait_nxt;
    logic [7:0]  w_lfsr_nxt;
    logic        w_passed_nxt;
    logic        w_active;
    logic        w_fb;
    logic [5:0]  w_reload;
    logic [9:0]  w_speed;

    assign w_active = i_frame_tick & i_run & ~i_restart;
    assign w_fb     = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];
    // Gap uses the LFSR value before this tick's advance.
    assign w_reload = MIN_GAP + {1'b0, r_lfsr[4:0]};
    assign w_speed  = {6'd0, i_speed};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_xpos     <= 10'd0;
            r_wait_cnt <= 6'd0;
            r_lfsr     <= LFSR_SEED;
            r_passed   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_xpos     <= w_xpos_nxt;
            r_wait_cnt <= w_wait_nxt;
            r_lfsr     <= w_lfsr_nxt;
            r_passed   <= w_passed_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_xpos_nxt   = r_xpos;
        w_wait_nxt   = r_wait_cnt;
        w_lfsr_nxt   = r_lfsr;
        w_passed_nxt = 1'b0;
        if (i_restart) begin
            w_state_nxt = S_IDLE;
            w_xpos_nxt  = 10'd0;
            w_wait_nxt  = 6'd0;
        end else if (w_active) begin
            w_lfsr_nxt = {r_lfsr[6:0], w_fb};
            case (r_state)
                S_IDLE: begin
                    w_state_nxt = S_WAIT;
                    w_wait_nxt  = w_reload;
                end
                S_WAIT: begin
                    if (r_wait_cnt != 6'd0) begin
                        w_wait_nxt = r_wait_cnt - 6'd1;
                    end else begin
                        w_state_nxt = S_SCROLL;
                        w_xpos_nxt  = SPAWN_X;
                    end
                end
                S_SCROLL: begin
                    // Park at 0: the renderer window can never match there.
                    if (r_xpos <= w_speed) begin
                        w_state_nxt  = S_WAIT;
                        w_xpos_nxt   = 10'd0;
                        w_wait_nxt   = w_reload;
                        w_passed_nxt = 1'b1;
                    end else begin
                        w_xpos_nxt = r_xpos - w_speed;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_xpos_nxt  = 10'd0;
                    w_wait_nxt  = 6'd0;
                end
            endcase
        end
    end

    assign o_xpos   = r_xpos[9:CONV];
    assign o_passed = r_passed;

endmodule

// File: tb/tb_bg_scroller.sv
// Random and directed stimulus for bg_scroller (CONV=0 and CONV=1 instances), checked against a frame-level model.
module tb_bg_scroller;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       i_frame_tick = 1'b0;
    logic       i_run = 1'b0;
    logic       i_restart = 1'b0;
    logic [3:0] i_speed = 4'd0;
    logic [9:0] x0;
    logic [8:0] x1;
    logic       p0, p1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bg_scroller #(.CONV(0)) dut0 (
        .clk(clk), .rst(rst), .i_frame_tick(i_frame_tick), .i_run(i_run),
        .i_restart(i_restart), .i_speed(i_speed), .o_xpos(x0), .o_passed(p0)
    );

    bg_scroller #(.CONV(1)) dut1 (
        .clk(clk), .rst(rst), .i_frame_tick(i_frame_tick), .i_run(i_run),
        .i_restart(i_restart), .i_speed(i_speed), .o_xpos(x1), .o_passed(p1)
    );

    // Frame-level model: phase 0 idle, 1 parked, 2 on screen.
    int       m_phase;
    int       m_x;
    int       m_cnt;
    bit [7:0] m_lfsr;
    bit       m_passed;

    function automatic bit [7:0] lfsr_adv(input bit [7:0] v);
        return {v[6:0], ^(v & 8'hB8)};
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase = 0; m_x = 0; m_cnt = 0; m_lfsr = 8'hA5; m_passed = 0;
        end else begin
            m_passed = 0;
            if (i_restart) begin
                m_phase = 0; m_x = 0; m_cnt = 0;
            end else if (i_run && i_frame_tick) begin
                int gap;
                gap = 8 + (m_lfsr % 32);
                m_lfsr = lfsr_adv(m_lfsr);
                if (m_phase == 0) begin
                    m_phase = 1; m_cnt = gap;
                end else if (m_phase == 1) begin
                    if (m_cnt > 0) m_cnt = m_cnt - 1;
                    else begin m_phase = 2; m_x = 648; end
                end else if (m_x <= int'(i_speed)) begin
                    m_x = 0; m_passed = 1; m_cnt = gap; m_phase = 1;
                end else begin
                    m_x = m_x - int'(i_speed);
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            chk("xpos_conv0", int'(x0), m_x);
            chk("xpos_conv1", int'(x1), m_x / 2);
            chk("passed_conv0", int'(p0), int'(m_passed));
            chk("passed_conv1", int'(p1), int'(m_passed));
        end
    end

    task automatic step(input bit t);
        @(negedge clk);
        i_frame_tick = t;
    endtask

    task automatic tick1();
        step(1'b1);
        step(1'b0);
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timeout waiting, got phase %0d expected progress", name, m_phase);
    endtask

    initial begin
        bit [7:0] saved_lfsr;
        int g;
        // Tick during reset is lost.
        i_frame_tick = 1'b1;
        repeat (2) @(negedge clk);
        i_frame_tick = 1'b0;
        rst = 1'b0;
        chk("reset_xpos", int'(x0), 0);
        chk("reset_passed", int'(p0), 0);

        repeat (5) tick1();
        chk("frozen_xpos", int'(x0), 0);
        chk("frozen_phase", m_phase, 0);

        i_run = 1'b1; i_speed = 4'd4;
        tick1();
        chk("first_gap", m_cnt, 13);
        chk("lfsr_a5_next", int'(m_lfsr), 'h4A);
        repeat (13) tick1();
        chk("parked_xpos", int'(x0), 0);
        tick1();
        chk("spawn_conv0", int'(x0), 648);
        chk("spawn_conv1", int'(x1), 324);
        tick1();
        chk("scroll_644", int'(x0), 644);

        g = 0;
        while (m_x != 4 && g < 300) begin tick1(); g++; end
        if (g >= 300) timeout("reach_x4");
        tick1();
        chk("pass_pulse", int'(p0), 1);
        chk("pass_xpos", int'(x0), 0);
        step(1'b0);
        chk("pass_one_cycle", int'(p0), 0);

        g = 0;
        while (m_phase != 2 && g < 100) begin tick1(); g++; end
        if (g >= 100) timeout("respawn");
        repeat (12) tick1();
        chk("at_600", int'(x0), 600);
        i_speed = 4'd0;
        repeat (10) tick1();
        chk("speed0_hold", int'(x0), 600);
        i_speed = 4'd7; i_run = 1'b0;
        repeat (3) tick1();
        chk("run0_hold", int'(x0), 600);
        i_run = 1'b1;
        tick1();
        chk("resume_593", int'(x0), 593);

        i_speed = 4'd5;
        repeat (118) tick1();
        chk("at_3", int'(x0), 3);
        saved_lfsr = m_lfsr;
        @(negedge clk);
        i_frame_tick = 1'b1; i_restart = 1'b1;
        @(negedge clk);
        i_frame_tick = 1'b0; i_restart = 1'b0;
        chk("restart_xpos", int'(x0), 0);
        chk("restart_passed", int'(p0), 0);
        chk("restart_lfsr", int'(m_lfsr), int'(saved_lfsr));
        chk("restart_phase", m_phase, 0);

        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            i_frame_tick = ($urandom_range(1, 0) == 1);
            i_run        = ($urandom_range(9, 0) != 0);
            i_restart    = ($urandom_range(49, 0) == 0);
            i_speed      = 4'($urandom_range(15, 0));
        end

        @(negedge clk);
        i_frame_tick = 1'b0; i_restart = 1'b0; i_run = 1'b1; i_speed = 4'd3;
        g = 0;
        while (!(m_phase == 2 && m_x > 100) && g < 200) begin tick1(); g++; end
        if (g >= 200) timeout("reach_scroll");
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_conv0", int'(x0), 0);
        chk("async_rst_conv1", int'(x1), 0);
        chk("async_rst_passed", int'(p0), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) tick1();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bg_scroller.md
Name: bg_scroller

Overview:
- Upstream position generator for the background sprite renderer; it produces the sprite x position that the renderer consumes.
- Once per frame it moves the background sprite (cloud/obstacle) left by the game speed.
- When the sprite leaves the left edge, it parks it off-screen for a pseudo-random number of frames, then respawns it just beyond the right edge.
- It also emits a one-cycle "passed" pulse for the score logic.

Parameters:
CONV, 0, low bits dropped from positions; o_xpos is [9:CONV] (position units of 2^CONV pixels).
SPAWN_X, 10'd648, full-pixel respawn x. The sprite occupies hpos SPAWN_X-8..SPAWN_X-1, so it enters from the right edge.
MIN_GAP, 6'd8, minimum parked frames between passes (must be ≤ 32).
LFSR_SEED, 8'hA5, LFSR reset value (must be nonzero).

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-high
i_frame_tick  input  1  one-cycle pulse per frame (start of vblank)
i_run  input  1  level; 1 = game running, 0 = freeze all state
i_restart  input  1  synchronous one-cycle pulse; return to IDLE
i_speed  input  4  pixels moved per frame, 0..15
o_xpos  output  10-CONV  sprite x position, = xpos_q[9:CONV]; feeds the renderer's i_xpos
o_passed  output  1  one-cycle pulse when the sprite exits the left edge

Behaviour:
- Single clock domain. Reset: asynchronous assert, active-high. During reset:
  - state=IDLE, xpos_q=0, wait_cnt=0, lfsr=LFSR_SEED
  - o_xpos=0, o_passed=0
- All outputs are registered. xpos_q is a 10-bit full-pixel register; o_xpos is its upper bits (no extra delay).
- Parked position: xpos_q=0. The renderer window (hpos-xpos+8 < 8) then never matches a visible or blanking hpos (0..799), so the sprite is invisible.
- LFSR (8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1):
  - fb = b7^b5^b4^b3; next = {lfsr[6:0], fb}.
  - Advances only on an "active tick" (i_frame_tick & i_run & !i_restart), after its current value is used.
  - Example: A5 -> 4A.
- Gap reload: wait_cnt <= MIN_GAP + lfsr[4:0] (6 bits, no overflow for legal MIN_GAP), using the pre-advance lfsr value.
- Priority, evaluated per clock:
  1. i_restart=1: state=IDLE, xpos_q=0, wait_cnt=0, o_passed=0. LFSR is untouched. Overrides a simultaneous frame tick.
  2. i_run=0: hold all state; o_passed=0; frame ticks are ignored.
  3. Active tick: state machine below.
  4. Otherwise: hold; o_passed=0.
- State machine (transitions only on active tick):
  - IDLE -> WAIT: reload wait_cnt; xpos_q stays 0.
  - WAIT, wait_cnt != 0: wait_cnt -= 1.
  - WAIT, wait_cnt == 0: -> SCROLL, xpos_q <= SPAWN_X.
  - SCROLL, xpos_q <= i_speed: xpos_q <= 0, o_passed <= 1 for exactly one cycle, reload wait_cnt, -> WAIT.
  - SCROLL, otherwise: xpos_q <= xpos_q - i_speed (never underflows).
- Boundaries:
  - i_speed=0 in SCROLL: xpos_q holds (it is > 0), no pass.
  - i_speed changes between ticks take effect on the next tick.
  - Consecutive-cycle ticks are legal; each is processed.
  - A frame tick during reset is lost.
  - Async reset mid-SCROLL zeroes o_xpos immediately, without a clock edge.
- Latency: o_xpos and o_passed update on the clock edge of the active tick, so they are visible the cycle after the tick is sampled.

Test Plan:
1. Reset, then 5 ticks with i_run=0 -> o_xpos=0, o_passed=0 throughout, state IDLE.
2. i_run=1, CONV=0, first tick -> WAIT with wait_cnt=13 (8+5 from A5). Next 13 ticks -> o_xpos stays 0. 14th tick -> o_xpos=648.
3. SCROLL, i_speed=4, start 648 -> after k ticks o_xpos=648-4k. At xpos=4 the next tick gives o_xpos=0 and o_passed high exactly 1 cycle. wait_cnt reloads to 8+lfsr[4:0] per the model.
4. SCROLL at 600, i_speed=0 -> holds 600 over 10 ticks. Set i_speed=7 and drop i_run for 3 ticks -> holds 600. Restore i_run -> 593.
5. i_restart coincident with a tick at xpos=3, i_speed=5 -> IDLE, o_xpos=0, o_passed stays 0, LFSR unchanged.
6. CONV=1 build, spawn -> o_xpos=324. Async rst pulse between clock edges mid-SCROLL -> o_xpos=0 immediately.
